// File: rtl/apb_mem_backend.sv
// apb_mem_backend: word memory behind APB_Slave with byte strobes, fixed wait states and
// error detection. Define APB_MEM_STATS_EN to add saturating wr/rd/err transfer counters.
module apb_mem_backend #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned PROT_BASE   = 'h200
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    master_data_ready,
  input  logic [ADDR_WIDTH-1:0]   slave_address,
  input  logic [2:0]              slave_protection,
  input  logic                    slave_read_write,
  input  logic [DATA_WIDTH-1:0]   slave_write_data,
  input  logic [DATA_WIDTH/8-1:0] slave_strobe,
  output logic                    slave_data_valid,
  output logic [DATA_WIDTH-1:0]   slave_read_data,
  output logic                    slave_error
`ifdef APB_MEM_STATS_EN
  ,
  output logic [15:0]             wr_count,
  output logic [15:0]             rd_count,
  output logic [15:0]             err_count
`endif
);

  localparam int unsigned STRB_W  = DATA_WIDTH / 8;
  localparam int unsigned BYTE_SH = (STRB_W > 1) ? $clog2(STRB_W) : 0;
  localparam int unsigned MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L    = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   PROT_L     = (ADDR_WIDTH+1)'(PROT_BASE);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);
  localparam logic [CNT_W-1:0]      LAST_CNT   = CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DRAIN} state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [MEM_AW-1:0]       idx_q;
  logic                    wr_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]       strb_q;
  logic                    valid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    rerr_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  // Request decode: word index and error classification of the incoming request
  logic [ADDR_WIDTH:0] word_c;
  logic [MEM_AW-1:0]   idx_c;
  logic                err_c;
  logic                accept_c;
  logic                unused_prot;

  assign word_c      = (ADDR_WIDTH+1)'(slave_address >> BYTE_SH);
  assign idx_c       = MEM_AW'(slave_address >> BYTE_SH);
  assign err_c       = ((slave_address & ALIGN_MASK) != '0)
                     || (word_c >= DEPTH_L)
                     || (({1'b0, slave_address} >= PROT_L) && !slave_protection[0]);
  assign accept_c    = (state_q == S_IDLE) && master_data_ready;
  assign unused_prot = ^slave_protection[2:1];

  assign slave_data_valid = valid_q;
  assign slave_read_data  = rdata_q;
  assign slave_error      = rerr_q;

  // Control FSM with registered response outputs
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (master_data_ready) begin
            cnt_q <= '0;
            if (WAIT_CYCLES == 0) begin
              state_q <= S_RESP;
              valid_q <= 1'b1;
              rerr_q  <= err_c;
              rdata_q <= err_c ? '0 : mem_q[idx_c];
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == LAST_CNT) begin
            state_q <= S_RESP;
            valid_q <= 1'b1;
            rerr_q  <= err_q;
            rdata_q <= err_q ? '0 : mem_q[idx_q];
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RESP:  state_q <= S_DRAIN;
        S_DRAIN: if (!master_data_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Request capture; contents are only meaningful after an accept
  always_ff @(posedge pclk) begin
    if (accept_c) begin
      idx_q   <= idx_c;
      wr_q    <= slave_read_write;
      err_q   <= err_c;
      wdata_q <= slave_write_data;
      strb_q  <= slave_strobe;
    end
  end

  // Write commits on the edge that ends the response cycle
  always_ff @(posedge pclk) begin
    if (!preset && (state_q == S_RESP) && wr_q && !err_q) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (strb_q[b]) mem_q[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

`ifdef APB_MEM_STATS_EN
  logic [15:0] wr_cnt_q;
  logic [15:0] rd_cnt_q;
  logic [15:0] err_cnt_q;

  assign wr_count  = wr_cnt_q;
  assign rd_count  = rd_cnt_q;
  assign err_count = err_cnt_q;

  // Saturating per-response statistics
  always_ff @(posedge pclk) begin
    if (preset) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (state_q == S_RESP) begin
      if (err_q) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end else if (wr_q) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_apb_mem_backend.sv
// Testbench for apb_mem_backend: directed scenarios plus randomized traffic against a
// word-array reference model. Stats checks compile in when APB_MEM_STATS_EN is defined.
module tb_apb_mem_backend;

  localparam int unsigned DW        = 32;
  localparam int unsigned AW        = 10;
  localparam int unsigned DEPTH     = 256;
  localparam int unsigned WAITC     = 2;
  localparam int unsigned PROT_BASE = 'h200;
  localparam int          EXP_LAT   = WAITC + 1;

  logic          pclk = 1'b0;
  logic          preset;
  logic          master_data_ready;
  logic [AW-1:0] slave_address;
  logic [2:0]    slave_protection;
  logic          slave_read_write;
  logic [DW-1:0] slave_write_data;
  logic [3:0]    slave_strobe;
  logic          slave_data_valid;
  logic [DW-1:0] slave_read_data;
  logic          slave_error;
`ifdef APB_MEM_STATS_EN
  logic [15:0]   wr_count, rd_count, err_count;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] model_mem [DEPTH];

  apb_mem_backend #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_CYCLES(WAITC), .PROT_BASE(PROT_BASE)
  ) dut (
    .pclk(pclk), .preset(preset), .master_data_ready(master_data_ready),
    .slave_address(slave_address), .slave_protection(slave_protection),
    .slave_read_write(slave_read_write), .slave_write_data(slave_write_data),
    .slave_strobe(slave_strobe), .slave_data_valid(slave_data_valid),
    .slave_read_data(slave_read_data), .slave_error(slave_error)
`ifdef APB_MEM_STATS_EN
    , .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
`endif
  );

  always #5 pclk = ~pclk;

  // Reference rules: byte address, 4-byte words, privileged region at/above PROT_BASE
  function automatic logic model_err(input int unsigned addr, input logic [2:0] prot);
    return (addr % 4 != 0) || (addr / 4 >= DEPTH) || (addr >= PROT_BASE && !prot[0]);
  endfunction

  function automatic void model_write(input int unsigned addr, input logic [31:0] d,
                                      input logic [3:0] strb);
    for (int b = 0; b < 4; b++)
      if (strb[b]) model_mem[addr / 4][8*b +: 8] = d[8*b +: 8];
  endfunction

  task automatic do_xfer(input logic [AW-1:0] addr, input logic [2:0] prot, input logic rw,
                         input logic [31:0] wd, input logic [3:0] strb, output int lat,
                         output logic [31:0] rd, output logic er, output int pulses);
    @(negedge pclk);
    master_data_ready = 1'b1;
    slave_address     = addr;
    slave_protection  = prot;
    slave_read_write  = rw;
    slave_write_data  = wd;
    slave_strobe      = strb;
    lat = -1; pulses = 0; rd = '0; er = 1'b0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge pclk);
      if (c == 1) begin
        slave_address    = AW'($urandom);
        slave_protection = 3'($urandom);
        slave_read_write = 1'($urandom);
        slave_write_data = $urandom;
        slave_strobe     = 4'($urandom);
      end
      if (slave_data_valid) begin
        lat = c; rd = slave_read_data; er = slave_error; pulses = 1;
      end
    end
    master_data_ready = 1'b0;
    repeat (3) begin
      @(negedge pclk);
      if (slave_data_valid) pulses++;
    end
  endtask

  task automatic test_reset();
    total_cnt++; if (slave_data_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", slave_data_valid); else pass_cnt++;
    total_cnt++; if (slave_read_data !== 32'h0) $display("FAIL rst_rdata: got %h want 0", slave_read_data); else pass_cnt++;
    total_cnt++; if (slave_error !== 1'b0) $display("FAIL rst_error: got %b want 0", slave_error); else pass_cnt++;
`ifdef APB_MEM_STATS_EN
    total_cnt++; if ({wr_count, rd_count, err_count} !== 48'h0) $display("FAIL rst_stats: got %h want 0", {wr_count, rd_count, err_count}); else pass_cnt++;
`endif
  endtask

  task automatic test_init();
    int lat, pulses, bad;
    logic [31:0] rd, d;
    logic er;
    bad = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      d = $urandom;
      do_xfer(AW'(i * 4), 3'b001, 1'b1, d, 4'hF, lat, rd, er, pulses);
      if (er !== 1'b0 || lat !== EXP_LAT || pulses !== 1) bad++;
      model_write(i * 4, d, 4'hF);
    end
    total_cnt++; if (bad !== 0) $display("FAIL init_writes: got %0d bad transfers want 0", bad); else pass_cnt++;
  endtask

  task automatic test_write_read();
    int lat, pulses;
    logic [31:0] rd;
    logic er;
    do_xfer(10'd120, 3'b110, 1'b1, 32'd2772003, 4'hF, lat, rd, er, pulses);
    model_write(120, 32'd2772003, 4'hF);
    total_cnt++; if (lat !== EXP_LAT) $display("FAIL wr120_latency: got %0d want %0d", lat, EXP_LAT); else pass_cnt++;
    total_cnt++; if (er !== 1'b0) $display("FAIL wr120_error: got %b want 0", er); else pass_cnt++;
    do_xfer(10'd120, 3'b110, 1'b0, 32'h0, 4'h0, lat, rd, er, pulses);
    total_cnt++; if (rd !== 32'd2772003 || er !== 1'b0) $display("FAIL rd120: got %h/%b want %h/0", rd, er, 32'd2772003); else pass_cnt++;
  endtask

  task automatic test_partial_strobe();
    int lat, pulses;
    logic [31:0] rd;
    logic er;
    do_xfer(10'd0, 3'b000, 1'b1, 32'hAABBCCDD, 4'hF, lat, rd, er, pulses);
    do_xfer(10'd0, 3'b000, 1'b1, 32'h11223344, 4'b0101, lat, rd, er, pulses);
    model_write(0, 32'hAABBCCDD, 4'hF);
    model_write(0, 32'h11223344, 4'b0101);
    do_xfer(10'd0, 3'b000, 1'b0, 32'h0, 4'h0, lat, rd, er, pulses);
    total_cnt++; if (rd !== 32'hAA22CC44) $display("FAIL partial_strobe: got %h want aa22cc44", rd); else pass_cnt++;
    do_xfer(10'd0, 3'b000, 1'b1, 32'hDEADBEEF, 4'b0000, lat, rd, er, pulses);
    total_cnt++; if (er !== 1'b0) $display("FAIL zero_strobe_err: got %b want 0", er); else pass_cnt++;
    do_xfer(10'd0, 3'b000, 1'b0, 32'h0, 4'h0, lat, rd, er, pulses);
    total_cnt++; if (rd !== 32'hAA22CC44) $display("FAIL zero_strobe_data: got %h want aa22cc44", rd); else pass_cnt++;
  endtask

  task automatic test_misaligned();
    int lat, pulses;
    logic [31:0] rd;
    logic er;
    do_xfer(10'd122, 3'b000, 1'b1, 32'd2772003 + 32'd5, 4'hF, lat, rd, er, pulses);
    total_cnt++; if (er !== 1'b1) $display("FAIL misalign_wr_err: got %b want 1", er); else pass_cnt++;
    do_xfer(10'd120, 3'b000, 1'b0, 32'h0, 4'h0, lat, rd, er, pulses);
    total_cnt++; if (rd !== model_mem[30]) $display("FAIL misalign_no_commit: got %h want %h", rd, model_mem[30]); else pass_cnt++;
    do_xfer(10'd125, 3'b000, 1'b0, 32'h0, 4'hF, lat, rd, er, pulses);
    total_cnt++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL misalign_rd: got %h/%b want 0/1", rd, er); else pass_cnt++;
  endtask

  task automatic test_protection();
    int lat, pulses;
    logic [31:0] rd;
    logic er;
    do_xfer(10'h200, 3'b000, 1'b1, 32'h5A5A0001, 4'hF, lat, rd, er, pulses);
    total_cnt++; if (er !== 1'b1) $display("FAIL prot_wr_unpriv: got %b want 1", er); else pass_cnt++;
    do_xfer(10'h200, 3'b001, 1'b0, 32'h0, 4'h0, lat, rd, er, pulses);
    total_cnt++; if (rd !== model_mem['h80] || er !== 1'b0) $display("FAIL prot_no_commit: got %h/%b want %h/0", rd, er, model_mem['h80]); else pass_cnt++;
    do_xfer(10'h200, 3'b001, 1'b1, 32'h5A5A0002, 4'hF, lat, rd, er, pulses);
    model_write('h200, 32'h5A5A0002, 4'hF);
    total_cnt++; if (er !== 1'b0) $display("FAIL prot_wr_priv: got %b want 0", er); else pass_cnt++;
    do_xfer(10'h200, 3'b000, 1'b0, 32'h0, 4'h0, lat, rd, er, pulses);
    total_cnt++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL prot_rd_unpriv: got %h/%b want 0/1", rd, er); else pass_cnt++;
    do_xfer(10'h1FC, 3'b000, 1'b0, 32'h0, 4'h0, lat, rd, er, pulses);
    total_cnt++; if (er !== 1'b0 || rd !== model_mem['h7F]) $display("FAIL prot_below_base: got %h/%b want %h/0", rd, er, model_mem['h7F]); else pass_cnt++;
  endtask

  task automatic test_handshake();
    int pulses, lat, p2;
    logic [31:0] rd;
    logic er;
    @(negedge pclk);
    master_data_ready = 1'b1;
    slave_address = 10'd8; slave_protection = 3'b000; slave_read_write = 1'b0; slave_strobe = 4'h0;
    pulses = 0;
    repeat (6) begin
      @(negedge pclk);
      if (slave_data_valid) pulses++;
    end
    total_cnt++; if (pulses !== 1) $display("FAIL hold_single_pulse: got %0d pulses want 1", pulses); else pass_cnt++;
    master_data_ready = 1'b0;
    do_xfer(10'd8, 3'b000, 1'b0, 32'h0, 4'h0, lat, rd, er, p2);
    total_cnt++; if (lat !== EXP_LAT || p2 !== 1 || rd !== model_mem[2]) $display("FAIL reaccept: got lat %0d pulses %0d data %h want %0d/1/%h", lat, p2, rd, EXP_LAT, model_mem[2]); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat, pulses, seen;
    logic [31:0] rd;
    logic er;
    @(negedge pclk);
    master_data_ready = 1'b1;
    slave_address = 10'd40; slave_protection = 3'b001; slave_read_write = 1'b1;
    slave_write_data = ~model_mem[10]; slave_strobe = 4'hF;
    @(negedge pclk);
    preset = 1'b1; master_data_ready = 1'b0;
    seen = 0;
    @(negedge pclk);
    if (slave_data_valid) seen++;
    preset = 1'b0;
    repeat (4) begin
      @(negedge pclk);
      if (slave_data_valid) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL reset_abort_valid: got %0d pulses want 0", seen); else pass_cnt++;
    do_xfer(10'd40, 3'b001, 1'b0, 32'h0, 4'h0, lat, rd, er, pulses);
    total_cnt++; if (lat !== EXP_LAT) $display("FAIL reset_idle_latency: got %0d want %0d", lat, EXP_LAT); else pass_cnt++;
    total_cnt++; if (rd !== model_mem[10]) $display("FAIL reset_no_commit: got %h want %h", rd, model_mem[10]); else pass_cnt++;
  endtask

  task automatic test_random();
    int lat, pulses;
    int unsigned addr;
    logic [31:0] rd, wd, exp_rd;
    logic [2:0] prot;
    logic [3:0] strb;
    logic rw, er, exp_er;
    for (int n = 0; n < 150; n++) begin
      addr = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'd3;
      prot = 3'($urandom); rw = 1'($urandom); wd = $urandom; strb = 4'($urandom);
      exp_er = model_err(addr, prot);
      exp_rd = exp_er ? 32'h0 : model_mem[(addr / 4) % DEPTH];
      do_xfer(AW'(addr), prot, rw, wd, strb, lat, rd, er, pulses);
      total_cnt++; if (lat !== EXP_LAT || pulses !== 1) $display("FAIL rnd%0d_handshake: got lat %0d pulses %0d want %0d/1", n, lat, pulses, EXP_LAT); else pass_cnt++;
      total_cnt++; if (er !== exp_er) $display("FAIL rnd%0d_err addr %h prot %b: got %b want %b", n, addr, prot, er, exp_er); else pass_cnt++;
      if (!rw) begin
        total_cnt++; if (rd !== exp_rd) $display("FAIL rnd%0d_rdata addr %h: got %h want %h", n, addr, rd, exp_rd); else pass_cnt++;
      end else if (!exp_er) begin
        model_write(addr, wd, strb);
      end
    end
  endtask

`ifdef APB_MEM_STATS_EN
  task automatic test_stats();
    int lat, pulses;
    logic [31:0] rd;
    logic er;
    @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    preset = 1'b0;
    do_xfer(10'h10, 3'b000, 1'b1, 32'h01020304, 4'hF, lat, rd, er, pulses);
    model_write('h10, 32'h01020304, 4'hF);
    do_xfer(10'h14, 3'b000, 1'b1, 32'h05060708, 4'hF, lat, rd, er, pulses);
    model_write('h14, 32'h05060708, 4'hF);
    do_xfer(10'h10, 3'b000, 1'b0, 32'h0, 4'h0, lat, rd, er, pulses);
    do_xfer(10'h11, 3'b000, 1'b1, 32'h0, 4'hF, lat, rd, er, pulses);
    total_cnt++; if (wr_count !== 16'd2) $display("FAIL stats_wr: got %0d want 2", wr_count); else pass_cnt++;
    total_cnt++; if (rd_count !== 16'd1) $display("FAIL stats_rd: got %0d want 1", rd_count); else pass_cnt++;
    total_cnt++; if (err_count !== 16'd1) $display("FAIL stats_err: got %0d want 1", err_count); else pass_cnt++;
  endtask
`endif

  initial begin
    preset = 1'b1;
    master_data_ready = 1'b0;
    slave_address = '0; slave_protection = '0; slave_read_write = 1'b0;
    slave_write_data = '0; slave_strobe = '0;
    repeat (2) @(negedge pclk);
    test_reset();
    preset = 1'b0;
    test_init();
    test_write_read();
    test_partial_strobe();
    test_misaligned();
    test_protection();
    test_handshake();
    test_reset_mid();
    test_random();
`ifdef APB_MEM_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
